// File: rtl/mul_div_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit_if                                              |
// | Description : Launch/result bundle between the EX stage and the iterative |
// |               multiply/divide unit.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  // EX-stage side: issues operations, observes stall and results
  modport master (
    output start_i, op_i, src1_i, src2_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  // Unit side
  modport slave (
    input  start_i, op_i, src1_i, src2_i,
    output busy_o, done_o, hi_o, lo_o
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit                                                 |
// | Description : Iterative one-bit-per-cycle multiply (shift-add) and divide |
// |               (restoring) unit writing HI/LO. Op codes: 00 MULTU, 01 MULT,|
// |               10 DIVU, 11 DIV. Signed ops are built only when the macro   |
// |               MDU_SIGNED_EN is defined; otherwise op_i[0] is ignored.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opa_q, opa_d;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // partial product high / partial remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier bits / dividend-then-quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] mag1_w, mag2_w;
  logic [WIDTH:0]   mul_sum_w;
  logic [WIDTH:0]   div_shift_w;
  logic             div_ge_w;
  logic [WIDTH-1:0] div_rem_w;
  logic [WIDTH-1:0] res_hi_w, res_lo_w;

`ifdef MDU_SIGNED_EN
  logic             sgn1_w, sgn2_w;
  logic             neg_res_q;   // negate product or quotient at commit
  logic             neg_rem_q;   // negate remainder at commit (dividend sign)
  logic [2*WIDTH-1:0] prod_w;

  // Convert signed operands to magnitudes at launch
  always_comb begin
    sgn1_w = bus.op_i[0] & bus.src1_i[WIDTH-1];
    sgn2_w = bus.op_i[0] & bus.src2_i[WIDTH-1];
    mag1_w = sgn1_w ? -bus.src1_i : bus.src1_i;
    mag2_w = sgn2_w ? -bus.src2_i : bus.src2_i;
  end

  // Capture the sign fixups at launch; a zero divisor suppresses quotient fixup
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == S_IDLE && bus.start_i) begin
      neg_res_q <= (sgn1_w ^ sgn2_w) & ~(bus.op_i[1] & (bus.src2_i == '0));
      neg_rem_q <= sgn1_w;
    end
  end

  // Apply sign fixups to the magnitude result
  always_comb begin
    prod_w   = {acc_hi_q, acc_lo_q};
    res_hi_w = acc_hi_q;
    res_lo_w = acc_lo_q;
    if (is_div_q) begin
      if (neg_res_q) res_lo_w = -acc_lo_q;
      if (neg_rem_q) res_hi_w = -acc_hi_q;
    end else if (neg_res_q) begin
      {res_hi_w, res_lo_w} = -prod_w;
    end
  end
`else
  logic unused_op0_w;
  assign unused_op0_w = bus.op_i[0];

  // Unsigned-only build: operands and results pass straight through
  always_comb begin
    mag1_w   = bus.src1_i;
    mag2_w   = bus.src2_i;
    res_hi_w = acc_hi_q;
    res_lo_w = acc_lo_q;
  end
`endif

  // One iteration of shift-add multiply and of restoring divide
  always_comb begin
    mul_sum_w   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opa_q : '0)};
    div_shift_w = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge_w    = div_shift_w >= {1'b0, opa_q};
    div_rem_w   = div_ge_w ? (div_shift_w[WIDTH-1:0] - opa_q) : div_shift_w[WIDTH-1:0];
  end

  // Sequencer next state: launch, iterate WIDTH times, commit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d  = S_CALC;
          cnt_d    = CNT_W'(WIDTH);
          is_div_d = bus.op_i[1];
          acc_hi_d = '0;
          if (bus.op_i[1]) begin
            opa_d    = mag2_w;
            acc_lo_d = mag1_w;
          end else begin
            opa_d    = mag1_w;
            acc_lo_d = mag2_w;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = div_rem_w;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_w};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum_w, acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        hi_d    = res_hi_w;
        lo_d    = res_lo_w;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; busy/done are registered views of the sequencer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= (state_q == S_CALC);
      done_q   <= (state_q == S_DONE);
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_div_unit                                              |
// | Description : Self-checking bench for mul_div_unit: directed and random    |
// |               operations against an arithmetic reference model.           |
// |               Honours MDU_SIGNED_EN the same way the design does.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [63:0] cur_res = '0;   // {hi,lo} the unit should currently hold

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: plain integer arithmetic on the architectural rules
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    bit            sgn;
    longint        sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]   r;
`ifdef MDU_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!op[1]) begin
      if (sgn) r = 64'(sa * sb);
      else     r = 64'(ua * ub);
    end else if (b == 32'd0) begin
      r = {a, 32'hFFFF_FFFF};
    end else if (sgn) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[31:0], sq[31:0]};
    end else begin
      r = {32'(ua % ub), 32'(ua / ub)};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    bus.op_i   = 2'($urandom_range(0, 3));
    bus.src1_i = $urandom;
    bus.src2_i = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (start sampled at the next edge) and check its whole timeline
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke_mid, input bit poke_done);
    logic [63:0] exp;
    logic [63:0] prev;
    exp  = model(op, a, b);
    prev = cur_res;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src1_i  = a;
    bus.src2_i  = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    scramble();
    check("done_c0", {63'd0, bus.done_o}, 64'd0);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      check("busy_run", {63'd0, bus.busy_o}, 64'd1);
      check("done_run", {63'd0, bus.done_o}, 64'd0);
      check("hold_run", {bus.hi_o, bus.lo_o}, prev);
      scramble();
      if (poke_mid && k == 9)   bus.start_i = 1'b1;
      if (k == 10)              bus.start_i = 1'b0;
      if (poke_done && k == 32) bus.start_i = 1'b1;
    end
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check("busy_done", {63'd0, bus.busy_o}, 64'd0);
    check("done_pulse", {63'd0, bus.done_o}, 64'd1);
    check("result", {bus.hi_o, bus.lo_o}, exp);
    cur_res = exp;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_done", {63'd0, bus.done_o}, 64'd0);
    check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    rst = 1'b0;

    // MULTU max*max, then back-to-back signed multiply
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_max", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
`ifdef MDU_SIGNED_EN
    check("mult_m3x7", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
`else
    check("mult_m3x7", {bus.hi_o, bus.lo_o}, 64'h0000_0006_FFFF_FFEB);
`endif
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
`ifdef MDU_SIGNED_EN
    check("div_m7d2", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100d7", {bus.hi_o, bus.lo_o}, 64'h0000_0002_0000_000E);

    // Divide by zero, with a start pulse landing in DONE that must be ignored
    run_op(2'b10, 32'd10, 32'd0, 1'b0, 1'b1);
    check("divu_by0", {bus.hi_o, bus.lo_o}, 64'h0000_000A_FFFF_FFFF);
    @(posedge clk); #1;
    check("done_drop", {63'd0, bus.done_o}, 64'd0);
    check("ign_done_b1", {63'd0, bus.busy_o}, 64'd0);
    @(posedge clk); #1;
    check("ign_done_b2", {63'd0, bus.busy_o}, 64'd0);

    // Signed corner cases
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // Start while busy is ignored; new start right after is accepted
    run_op(2'b00, 32'd5, 32'd6, 1'b1, 1'b0);
    check("multu_5x6", {bus.hi_o, bus.lo_o}, 64'd30);
    run_op(2'b00, 32'd123, 32'd456, 1'b0, 1'b0);

    // Reset in the middle of an operation
    bus.start_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src1_i  = 32'd9;
    bus.src2_i  = 32'd9;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {63'd0, bus.busy_o}, 64'd0);
    check("abort_done", {63'd0, bus.done_o}, 64'd0);
    check("abort_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    cur_res = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check("abort_nodone", {62'd0, bus.busy_o, bus.done_o}, 64'd0);
    end

    // Reset and start together: reset wins
    rst = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wins", {62'd0, bus.busy_o, bus.done_o}, 64'd0);

    // Random operations against the model
    for (int i = 0; i < 20; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
